// File: rtl/dual_counter_fault_monitor_pkg.sv
// dual_counter_fault_monitor_pkg: shared FSM encoding and fault-count helpers
package dual_counter_fault_monitor_pkg;
  localparam int FC_W = 4;
  typedef enum logic [1:0] {
    MONITOR = 2'd0,
    SUSPECT = 2'd1,
    RESYNC  = 2'd2,
    LOCKOUT = 2'd3
  } state_t;
  function automatic logic [FC_W-1:0] sat_inc(input logic [FC_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/dual_counter_fault_monitor_pulse_stretcher.sv
// dual_counter_fault_monitor_pulse_stretcher: loadable down-counter giving a LEN-cycle level
module dual_counter_fault_monitor_pulse_stretcher #(
  parameter int unsigned LEN = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic active,
  output logic last
);
  logic [3:0] cnt;
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else cnt <= load ? 4'(LEN) : cnt - {3'b0, active};
  assign active = |cnt;
  assign last = cnt == 4'd1;
endmodule

// File: rtl/dual_counter_fault_monitor.sv
// dual_counter_fault_monitor: filters counter disagreements, resyncs on faults, locks out on repeats
module dual_counter_fault_monitor
  import dual_counter_fault_monitor_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int PERSIST       = 3,
  parameter int RESYNC_CYCLES = 2,
  parameter int MAX_FAULTS    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] cnt_a,
  input  logic [WIDTH-1:0] cnt_b,
  input  logic             mismatch_in,
  input  logic             clear,
  output logic             resync,
  output logic             fault_pulse,
  output logic [FC_W-1:0]  fault_count,
  output logic             lockout,
  output logic [1:0]       state_o
);
  state_t state;
  logic [3:0] persist_cnt;
  logic [FC_W-1:0] fc_inc;
  logic mis, watching, confirm, go_lock, rs_active, rs_last;
  always_comb begin
    mis      = mismatch_in | (cnt_a != cnt_b);
    watching = state == MONITOR || state == SUSPECT;
    confirm  = mis && watching && (persist_cnt + 4'd1 == 4'(PERSIST));
    fc_inc   = sat_inc(fault_count);
    go_lock  = confirm && !clear && fc_inc >= FC_W'(MAX_FAULTS);
  end
  dual_counter_fault_monitor_pulse_stretcher #(.LEN(RESYNC_CYCLES)) u_stretch (
    .clk    (clk),
    .reset  (reset),
    .load   (confirm && !go_lock),
    .active (rs_active),
    .last   (rs_last)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state       <= MONITOR;
      persist_cnt <= '0;
      fault_pulse <= 1'b0;
      fault_count <= '0;
      lockout     <= 1'b0;
    end else begin
      fault_pulse <= confirm;
      fault_count <= clear ? '0 : confirm ? fc_inc : fault_count;
      persist_cnt <= (mis && watching && !confirm) ? persist_cnt + 4'd1 : '0;
      lockout     <= go_lock || (lockout && !clear);
      state       <= confirm            ? (go_lock ? LOCKOUT : RESYNC) :
                     state == RESYNC    ? (rs_last ? MONITOR : RESYNC) :
                     state == LOCKOUT   ? (clear ? MONITOR : LOCKOUT) :
                     mis                ? SUSPECT : MONITOR;
    end
  assign resync  = rs_active | lockout;
  assign state_o = state;
endmodule

// File: tb/tb_dual_counter_fault_monitor.sv
// tb_dual_counter_fault_monitor: randomized and directed checks against a run-length reference model
module tb_dual_counter_fault_monitor;
  localparam int W = 4, P = 3, RC = 2, MF = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [W-1:0] cnt_a = '0, cnt_b = '0;
  logic mismatch_in = 1'b0, clear = 1'b0;
  logic resync, fault_pulse, lockout;
  logic [3:0] fault_count;
  logic [1:0] state_o;
  int vectors = 0, miscompares = 0;
  int run, rs_left, faults;
  bit locked, pulse;

  always #5 clk = ~clk;

  dual_counter_fault_monitor #(.WIDTH(W), .PERSIST(P), .RESYNC_CYCLES(RC), .MAX_FAULTS(MF)) dut (
    .clk(clk), .reset(reset), .cnt_a(cnt_a), .cnt_b(cnt_b), .mismatch_in(mismatch_in),
    .clear(clear), .resync(resync), .fault_pulse(fault_pulse), .fault_count(fault_count),
    .lockout(lockout), .state_o(state_o)
  );

  function automatic logic [8:0] obs();
    return {resync, fault_pulse, fault_count, lockout, state_o};
  endfunction

  // Expected outputs from the model: locked dominates, then an ongoing resync, then a mismatch run.
  function automatic logic [8:0] expv();
    logic [1:0] st;
    st = locked ? 2'd3 : rs_left > 0 ? 2'd2 : run > 0 ? 2'd1 : 2'd0;
    return {locked || rs_left > 0, pulse, 4'(faults), locked, st};
  endfunction

  task automatic model_reset();
    run = 0; rs_left = 0; faults = 0; locked = 0; pulse = 0;
  endtask

  task automatic cycle(input logic [W-1:0] a, input logic [W-1:0] b, input logic mi, input logic cl);
    bit m;
    int nf;
    @(negedge clk);
    cnt_a = a; cnt_b = b; mismatch_in = mi; clear = cl;
    @(posedge clk);
    m = mi || (a != b);
    pulse = 0;
    if (locked) begin
      if (cl) locked = 0;
    end else if (rs_left > 0) rs_left--;
    else if (m) begin
      run++;
      if (run == P) begin
        run = 0; pulse = 1;
        nf = faults < 15 ? faults + 1 : 15;
        faults = nf;
        if (!cl && nf >= MF) locked = 1; else rs_left = RC;
      end
    end else run = 0;
    if (cl) faults = 0;
    #1;
  endtask

  task automatic test_reset();
    mismatch_in = 1'b1;
    #2 reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs() !== 9'd0) begin miscompares++; $display("FAIL reset_async got %b want %b", obs(), 9'd0); end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (obs() !== 9'd0) begin miscompares++; $display("FAIL reset_held got %b want %b", obs(), 9'd0); end
    @(negedge clk);
    mismatch_in = 1'b0; reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(4'd7, 4'd7, 1'b0, 1'b0);
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL reset_release cyc %0d got %b want %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_transient();
    for (int i = 0; i < 4; i++) begin
      cycle(4'd5, i < 2 ? 4'd6 : 4'd5, 1'b0, 1'b0);
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL transient cyc %0d got %b want %b", i, obs(), expv()); end
    end
    vectors++;
    if (fault_count !== 4'd0 || state_o !== 2'd0) begin
      miscompares++; $display("FAIL transient_end got cnt=%0d st=%0d want 0/0", fault_count, state_o);
    end
  endtask

  task automatic test_confirm();
    int hi = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(4'd3, 4'd3, i < 3, 1'b0);
      hi += resync;
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL confirm cyc %0d got %b want %b", i, obs(), expv()); end
    end
    vectors++;
    if (hi != RC) begin miscompares++; $display("FAIL confirm_resync_len got %0d want %0d", hi, RC); end
  endtask

  task automatic test_lockout();
    for (int k = 0; k < 10 && !locked; k++)
      for (int i = 0; i < 3 + RC; i++) begin
        cycle(4'd1, 4'd1, i < 3, 1'b0);
        vectors++;
        if (obs() !== expv()) begin miscompares++; $display("FAIL lockout_build k%0d cyc %0d got %b want %b", k, i, obs(), expv()); end
      end
    for (int i = 0; i < 55; i++) begin
      cycle(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
      vectors++;
      if (obs() !== expv() || resync !== 1'b1) begin miscompares++; $display("FAIL lockout_hold cyc %0d got %b want %b", i, obs(), expv()); end
    end
    for (int i = 0; i < 2; i++) begin
      cycle(4'd2, 4'd2, 1'b0, i == 0);
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL lockout_clear cyc %0d got %b want %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_ignore_resync();
    int pulses = 0;
    for (int i = 0; i < 3 + RC + 3; i++) begin
      cycle(4'd9, 4'd9, 1'b1, 1'b0);
      pulses += fault_pulse;
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL ignore_resync cyc %0d got %b want %b", i, obs(), expv()); end
    end
    vectors++;
    if (pulses != 2) begin miscompares++; $display("FAIL ignore_resync_pulses got %0d want 2", pulses); end
    for (int i = 0; i < RC + 2; i++) cycle(4'd0, 4'd0, 1'b0, i == 0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 4; i++) cycle(4'd2, 4'd8, 1'b0, 1'b0);
    vectors++;
    if (state_o !== 2'd2 || resync !== 1'b1) begin miscompares++; $display("FAIL async_setup got st=%0d rs=%b want 2/1", state_o, resync); end
    #2 reset = 1'b0;
    #1;
    model_reset();
    vectors++;
    if (obs() !== expv()) begin miscompares++; $display("FAIL async_midresync got %b want %b", obs(), expv()); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_clear_confirm();
    for (int k = 0; k < MF - 1; k++)
      for (int i = 0; i < 3 + RC; i++) cycle(4'd4, 4'd4, i < 3, 1'b0);
    for (int i = 0; i < 3; i++) cycle(4'd4, 4'd4, 1'b1, i == 2);
    vectors++;
    if (obs() !== expv() || state_o !== 2'd2 || lockout !== 1'b0 || fault_count !== 4'd0 || fault_pulse !== 1'b1) begin
      miscompares++; $display("FAIL clear_confirm got %b want %b", obs(), expv());
    end
    for (int i = 0; i < RC + 1; i++) begin
      cycle(4'd4, 4'd4, 1'b0, 1'b0);
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL clear_confirm_after cyc %0d got %b want %b", i, obs(), expv()); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      logic [W-1:0] a, b;
      a = 4'($urandom);
      b = ($urandom_range(0, 5) == 0) ? 4'($urandom) : a;
      cycle(a, b, $urandom_range(0, 3) == 0, $urandom_range(0, 40) == 0);
      vectors++;
      if (obs() !== expv()) begin miscompares++; $display("FAIL random cyc %0d got %b want %b", i, obs(), expv()); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_transient();
    test_confirm();
    test_lockout();
    test_ignore_resync();
    test_async_reset();
    test_clear_confirm();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
